mem_stage: RTL and testbench

- Pipeline MEM stage that sits directly downstream of the EXE stage and upstream of the WB stage.
- Accepts the ES-to-MS bus and waits for the data-SRAM response of any accepted load or store.
- Aligns and extends load data, then passes the result to WB.
- Drives the forwarding/blocking bus toward ID and the exception/ertn hints back to EXE.
- Discards SRAM responses that belong to flushed instructions.

---
 rtl/mem_stage_pkg.sv | 76 +++++++
 rtl/mem_load_align.sv | 35 +++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, exception codes and the
// packed layouts of the ES->MS, MS->WS and MS->ID forwarding buses.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 171;
  localparam int MS_TO_WS_BUS_WD = 163;
  localparam int MS_FORWARD_WD   = 45;
  localparam int CANCEL_CNT_WD   = 2;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef struct packed {
    logic        st_w;
    logic        rdcntid;
    logic        ertn;
    logic        esubcode;
    logic [5:0]  ecode;
    logic        ex;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        csr_we;
    logic [1:0]  addr;
    logic        ld_w;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        st_b;
    logic        st_h;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  // spare bits are driven to zero and keep the WB bus width stable
  typedef struct packed {
    logic        rdcntid;
    logic        ertn;
    logic        esubcode;
    logic [5:0]  ecode;
    logic        ex;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        csr_we;
    logic [2:0]  spare;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        csr_re;
    logic        csr_we;
    logic        rdcntid;
    logic        ertn;
    logic        ex;
    logic        load_block;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        valid;
  } ms_forward_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half of the raw
// SRAM word and sign- or zero-extends it to 32 bits.
module mem_load_align (
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_i,
  input  logic        ld_w_i,
  input  logic        ld_b_i,
  input  logic        ld_bu_i,
  input  logic        ld_h_i,
  input  logic        ld_hu_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

    data_o = 32'h0;
    if (ld_w_i)       data_o = raw_i;
    else if (ld_b_i)  data_o = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_bu_i) data_o = {24'h0, byte_sel};
    else if (ld_h_i)  data_o = {{16{half_sel[15]}}, half_sel};
    else if (ld_hu_i) data_o = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// aligns load data and hands the result to WB; drops responses of flushed entries.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       final_ex,
  input  logic                       back_ertn_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       es_mem_req_accepted,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  output logic                       ms_ertn_flush,
  output logic                       ms_to_es_valid,
  output logic                       ms_to_es_ex
);

  typedef logic [CANCEL_CNT_WD:0] cnt_ext_t;
  localparam logic [CANCEL_CNT_WD-1:0] CNT_MAX = '1;

  es_to_ms_bus_t             bus_q;
  ms_to_ws_bus_t             ws_bus;
  ms_forward_t               fwd_bus;
  logic                      ms_valid_q, ms_valid_d;
  logic                      wait_data_q, wait_data_d;
  logic                      rbuf_valid_q, rbuf_valid_d;
  logic [31:0]               rbuf_q;
  logic [CANCEL_CNT_WD-1:0]  cancel_cnt_q, cancel_cnt_d;
  cnt_ext_t                  cnt_sum;
  logic                      flush, data_ok_use, data_ok_drop, ms_ready_go;
  logic                      es_fire, ms_fire, rbuf_capture;
  logic                      orphan_wait, orphan_new;
  logic [31:0]               raw_data, load_data, final_result;
  logic                      unused_store_flags;

  // Handshakes: a transfer happens on a clock edge where valid && allowin are
  // both high; valid never depends on the downstream allowin.
  always_comb begin
    flush          = final_ex | back_ertn_flush;
    data_ok_use    = data_sram_data_ok & (cancel_cnt_q == '0);
    data_ok_drop   = data_sram_data_ok & (cancel_cnt_q != '0);
    ms_ready_go    = ~wait_data_q | data_ok_use | rbuf_valid_q;
    ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid_q & ms_ready_go;
    es_fire        = es_to_ms_valid & ms_allowin;
    ms_fire        = ms_to_ws_valid & ws_allowin;
    rbuf_capture   = ms_valid_q & wait_data_q & data_ok_use & ~ws_allowin & ~flush;

    // every request still in flight at a flush owes one response to discard
    orphan_wait  = flush & wait_data_q & ~data_ok_use;
    orphan_new   = flush & es_fire & es_mem_req_accepted;
    cnt_sum      = {1'b0, cancel_cnt_q} + cnt_ext_t'(orphan_wait)
                 + cnt_ext_t'(orphan_new) - cnt_ext_t'(data_ok_drop);
    cancel_cnt_d = (cnt_sum > cnt_ext_t'(CNT_MAX)) ? CNT_MAX
                                                   : cnt_sum[CANCEL_CNT_WD-1:0];

    ms_valid_d = ms_valid_q;
    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    wait_data_d = wait_data_q;
    if (flush)            wait_data_d = 1'b0;
    else if (es_fire)     wait_data_d = es_mem_req_accepted;
    else if (data_ok_use) wait_data_d = 1'b0;

    rbuf_valid_d = rbuf_valid_q;
    if (flush)             rbuf_valid_d = 1'b0;
    else if (rbuf_capture) rbuf_valid_d = 1'b1;
    else if (ms_fire)      rbuf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      wait_data_q  <= 1'b0;
      rbuf_valid_q <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      wait_data_q  <= wait_data_d;
      rbuf_valid_q <= rbuf_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (es_fire)      bus_q  <= es_to_ms_bus_t'(es_to_ms_bus);
    if (rbuf_capture) rbuf_q <= data_sram_rdata;
  end

  assign raw_data = rbuf_valid_q ? rbuf_q : data_sram_rdata;

  mem_load_align u_align (
    .raw_i   (raw_data),
    .addr_i  (bus_q.addr),
    .ld_w_i  (bus_q.ld_w),
    .ld_b_i  (bus_q.ld_b),
    .ld_bu_i (bus_q.ld_bu),
    .ld_h_i  (bus_q.ld_h),
    .ld_hu_i (bus_q.ld_hu),
    .data_o  (load_data)
  );

  assign final_result = bus_q.res_from_mem ? load_data : bus_q.result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.rdcntid      = bus_q.rdcntid;
    ws_bus.ertn         = bus_q.ertn;
    ws_bus.esubcode     = bus_q.esubcode;
    ws_bus.ecode        = bus_q.ecode;
    ws_bus.ex           = bus_q.ex;
    ws_bus.csr_re       = bus_q.csr_re;
    ws_bus.csr_num      = bus_q.csr_num;
    ws_bus.csr_wvalue   = bus_q.csr_wvalue;
    ws_bus.csr_wmask    = bus_q.csr_wmask;
    ws_bus.csr_we       = bus_q.csr_we;
    ws_bus.gr_we        = bus_q.gr_we;
    ws_bus.dest         = bus_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = bus_q.pc;

    fwd_bus              = '0;
    fwd_bus.csr_re       = bus_q.csr_re;
    fwd_bus.csr_we       = bus_q.csr_we;
    fwd_bus.rdcntid      = bus_q.rdcntid;
    fwd_bus.ertn         = bus_q.ertn;
    fwd_bus.ex           = bus_q.ex;
    fwd_bus.load_block   = ms_valid_q & bus_q.res_from_mem & ~ms_ready_go;
    fwd_bus.final_result = final_result;
    fwd_bus.dest         = bus_q.dest;
    fwd_bus.gr_we        = bus_q.gr_we & ms_valid_q;
    fwd_bus.valid        = ms_valid_q;
  end

  assign ms_to_ws_bus   = ws_bus;
  assign ms_forward     = fwd_bus;
  assign ms_ertn_flush  = ms_valid_q & bus_q.ertn;
  assign ms_to_es_valid = ms_valid_q;
  assign ms_to_es_ex    = ms_valid_q & bus_q.ex;

  // store flavours only matter to the SRAM request issued in EXE
  assign unused_store_flags = ^{bus_q.st_w, bus_q.st_b, bus_q.st_h};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized traffic
// against an in-order SRAM model and an expected-result queue.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int K_LDW = 0, K_LDB = 1, K_LDBU = 2, K_LDH = 3, K_LDHU = 4;
  localparam int K_ST = 5, K_ALU = 6, K_ALE = 7, K_ERTN = 8;

  logic                       clk = 1'b0;
  logic                       reset, final_ex, back_ertn_flush, ws_allowin;
  logic                       ms_allowin, es_to_ms_valid, es_mem_req_accepted;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ms_to_ws_valid, ms_ertn_flush, ms_to_es_valid, ms_to_es_ex;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_FORWARD_WD-1:0]   ms_forward;
  ms_to_ws_bus_t              ws;
  ms_forward_t                fwd;

  assign ws  = ms_to_ws_bus;
  assign fwd = ms_forward;

  mem_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .final_ex            (final_ex),
    .back_ertn_flush     (back_ertn_flush),
    .ws_allowin          (ws_allowin),
    .ms_allowin          (ms_allowin),
    .es_to_ms_valid      (es_to_ms_valid),
    .es_to_ms_bus        (es_to_ms_bus),
    .es_mem_req_accepted (es_mem_req_accepted),
    .data_sram_data_ok   (data_sram_data_ok),
    .data_sram_rdata     (data_sram_rdata),
    .ms_to_ws_valid      (ms_to_ws_valid),
    .ms_to_ws_bus        (ms_to_ws_bus),
    .ms_forward          (ms_forward),
    .ms_ertn_flush       (ms_ertn_flush),
    .ms_to_es_valid      (ms_to_es_valid),
    .ms_to_es_ex         (ms_to_es_ex)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard: {pc, final_result} of the instruction held in MEM
  logic [63:0] exp_q[$];
  typedef struct { logic [31:0] data; bit dead; } sram_ent_t;
  sram_ent_t   sram_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    final_ex            = 1'b0;
    back_ertn_flush     = 1'b0;
    ws_allowin          = 1'b1;
    es_to_ms_valid      = 1'b0;
    es_mem_req_accepted = 1'b0;
    data_sram_data_ok   = 1'b0;
    data_sram_rdata     = 32'hDEAD_BEEF;
  endtask

  function automatic es_to_ms_bus_t mk_ins(input int kind, input logic [1:0] addr,
                                           input logic [4:0] dest, input logic [31:0] result,
                                           input logic [31:0] pc);
    es_to_ms_bus_t b;
    b        = '0;
    b.addr   = addr;
    b.dest   = dest;
    b.result = result;
    b.pc     = pc;
    b.gr_we  = (kind != K_ST) && (kind != K_ALE) && (kind != K_ERTN);
    b.res_from_mem = (kind <= K_LDHU);
    case (kind)
      K_LDW:  b.ld_w  = 1'b1;
      K_LDB:  b.ld_b  = 1'b1;
      K_LDBU: b.ld_bu = 1'b1;
      K_LDH:  b.ld_h  = 1'b1;
      K_LDHU: b.ld_hu = 1'b1;
      K_ST:   b.st_w  = 1'b1;
      K_ALE:  begin b.ex = 1'b1; b.ecode = ECODE_ALE; end
      K_ERTN: b.ertn  = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

  // architectural load result from the raw word, by plain shifting/arithmetic
  function automatic logic [31:0] ref_load(input int kind, input logic [31:0] raw,
                                           input logic [1:0] addr);
    logic [31:0] b, h;
    b = (raw >> (8 * addr)) & 32'hFF;
    h = (raw >> (16 * addr[1])) & 32'hFFFF;
    case (kind)
      K_LDB:   return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
      K_LDBU:  return b;
      K_LDH:   return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      K_LDHU:  return h;
      default: return raw;
    endcase
  endfunction

  task automatic issue(input int kind, input logic [1:0] addr, input logic [4:0] dest,
                       input logic [31:0] result, input logic [31:0] pc, input logic req);
    es_to_ms_valid      = 1'b1;
    es_to_ms_bus        = mk_ins(kind, addr, dest, result, pc);
    es_mem_req_accepted = req;
  endtask

  bit            do_flush, ok_now, live_ok, m_ready, m_allowin, retire;
  bit            m_needs, m_got, m_load, es_pend, es_req;
  int            es_kind, dead_cnt;
  logic [31:0]   es_rdata, es_exp, es_pc;
  es_to_ms_bus_t es_ins;

  initial begin
    reset = 1'b1;
    idle();
    es_to_ms_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ertn_flush", ms_ertn_flush, 1'b0);
    chk("rst_to_es_ex", ms_to_es_ex, 1'b0);
    chk("rst_allowin", ms_allowin, 1'b1);
    reset = 1'b0;
    tick();

    // ld_b at byte 3, response in the second cycle in MEM
    issue(K_LDB, 2'd3, 5'd5, 32'h0, 32'h1C00_0100, 1'b1); #1;
    chk("a_allowin_empty", ms_allowin, 1'b1);
    tick(); idle(); #1;
    chk("a_wait_valid", ms_to_ws_valid, 1'b0);
    chk("a_load_block", fwd.load_block, 1'b1);
    chk("a_fwd_dest", fwd.dest, 5'd5);
    chk("a_fwd_gr_we", fwd.gr_we, 1'b1);
    chk("a_allowin_busy", ms_allowin, 1'b0);
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234; #1;
    chk("a_valid", ms_to_ws_valid, 1'b1);
    chk("a_result", ws.final_result, 32'hFFFF_FF80);
    chk("a_pc", ws.pc, 32'h1C00_0100);
    chk("a_block_clear", fwd.load_block, 1'b0);
    tick(); idle(); #1;
    chk("a_drained", ms_to_ws_valid, 1'b0);

    // ld_hu upper half
    issue(K_LDHU, 2'd2, 5'd6, 32'h0, 32'h1C00_0104, 1'b1); #1;
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000; #1;
    chk("b_result", ws.final_result, 32'h0000_8001);
    tick(); idle(); #1;

    // response while WB stalls for 3 cycles goes through the buffer
    issue(K_LDW, 2'd0, 5'd7, 32'h0, 32'h1C00_0108, 1'b1); #1;
    tick(); idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
    chk("c_ready", ms_to_ws_valid, 1'b1);
    chk("c_hold_allowin", ms_allowin, 1'b0);
    tick(); idle(); ws_allowin = 1'b0; data_sram_rdata = 32'h0BAD_F00D; #1;
    chk("c_rbuf_result", ws.final_result, 32'h1234_5678);
    chk("c_rbuf_block", fwd.load_block, 1'b0);
    tick(); idle(); ws_allowin = 1'b0; #1;
    chk("c_rbuf_valid", ms_to_ws_valid, 1'b1);
    tick(); idle(); #1;
    chk("c_handoff_result", ws.final_result, 32'h1234_5678);
    chk("c_handoff_allowin", ms_allowin, 1'b1);
    tick(); idle(); #1;
    chk("c_gone", ms_to_ws_valid, 1'b0);

    // flush while waiting; the stale response must be dropped
    issue(K_LDW, 2'd0, 5'd9, 32'h0, 32'h1C00_010C, 1'b1); #1;
    tick(); idle(); #1;
    chk("d_wait", ms_to_ws_valid, 1'b0);
    final_ex = 1'b1; #1;
    tick(); idle(); #1;
    chk("d_flushed_valid", fwd.valid, 1'b0);
    chk("d_flushed_allowin", ms_allowin, 1'b1);
    issue(K_LDW, 2'd0, 5'd10, 32'h0, 32'h1C00_0110, 1'b1); #1;
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_AAAA; #1;
    chk("d_stale_ignored", ms_to_ws_valid, 1'b0);
    chk("d_stale_block", fwd.load_block, 1'b1);
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_BBBB; #1;
    chk("d_young_valid", ms_to_ws_valid, 1'b1);
    chk("d_young_result", ws.final_result, 32'h0000_BBBB);
    tick(); idle(); #1;

    // response arriving in the flush cycle is consumed by the flushed entry
    issue(K_LDW, 2'd0, 5'd11, 32'h0, 32'h1C00_0114, 1'b1); #1;
    tick(); idle(); final_ex = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_EEEE; #1;
    tick(); idle();
    issue(K_LDW, 2'd0, 5'd12, 32'h0, 32'h1C00_0118, 1'b1); #1;
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_CCCC; #1;
    chk("e_same_cycle_valid", ms_to_ws_valid, 1'b1);
    chk("e_same_cycle_result", ws.final_result, 32'h0000_CCCC);
    tick(); idle(); #1;

    // store waits for its write response
    issue(K_ST, 2'd0, 5'd0, 32'h0000_0055, 32'h1C00_011C, 1'b1); #1;
    tick(); idle(); #1;
    chk("st_wait", ms_to_ws_valid, 1'b0);
    chk("st_no_block", fwd.load_block, 1'b0);
    tick(); idle(); data_sram_data_ok = 1'b1; #1;
    chk("st_done", ms_to_ws_valid, 1'b1);
    chk("st_result", ws.final_result, 32'h0000_0055);
    tick(); idle(); #1;

    // address-misaligned exception passes straight through
    issue(K_ALE, 2'd1, 5'd0, 32'h1C00_1001, 32'h1C00_0120, 1'b0); #1;
    tick(); idle(); #1;
    chk("ale_valid", ms_to_ws_valid, 1'b1);
    chk("ale_to_es_ex", ms_to_es_ex, 1'b1);
    chk("ale_to_es_valid", ms_to_es_valid, 1'b1);
    chk("ale_ws_ex", ws.ex, 1'b1);
    chk("ale_ws_ecode", ws.ecode, 6'h09);
    tick(); idle(); #1;
    chk("ale_drained_ex", ms_to_es_ex, 1'b0);

    issue(K_ERTN, 2'd0, 5'd0, 32'h0, 32'h1C00_0124, 1'b0); #1;
    tick(); idle(); #1;
    chk("ertn_flush_hint", ms_ertn_flush, 1'b1);
    tick(); idle(); #1;
    chk("ertn_drained", ms_ertn_flush, 1'b0);

    // randomized traffic
    m_needs = 0; m_got = 0; m_load = 0; es_pend = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      idle();
      dead_cnt = 0;
      foreach (sram_q[i]) if (sram_q[i].dead) dead_cnt++;
      do_flush = ($urandom_range(0, 19) == 0) && (dead_cnt < 2);
      if (do_flush) begin
        if ($urandom_range(0, 1) == 0) final_ex = 1'b1;
        else back_ertn_flush = 1'b1;
      end
      ws_allowin = do_flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      ok_now = (sram_q.size() > 0) && ($urandom_range(0, 2) == 0);
      data_sram_data_ok = ok_now;
      data_sram_rdata   = ok_now ? sram_q[0].data : $urandom;
      if (!es_pend && $urandom_range(0, 1) == 1) begin
        es_kind  = $urandom_range(0, 7);
        es_rdata = $urandom;
        es_pc    = 32'h1C01_0000 + 32'(cyc) * 4;
        es_ins   = mk_ins(es_kind, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
                          $urandom, es_pc);
        es_req   = (es_kind <= K_ST);
        es_exp   = (es_kind <= K_LDHU) ? ref_load(es_kind, es_rdata, es_ins.addr) : es_ins.result;
        es_pend  = 1;
      end
      es_to_ms_valid      = es_pend && !do_flush;
      es_to_ms_bus        = es_ins;
      es_mem_req_accepted = es_req;
      #1;
      live_ok   = ok_now && !sram_q[0].dead;
      m_ready   = (exp_q.size() > 0) && (!m_needs || m_got || live_ok);
      m_allowin = (exp_q.size() == 0) || (m_ready && ws_allowin);
      chk("r_ws_valid", ms_to_ws_valid, m_ready);
      chk("r_load_block", fwd.load_block, (exp_q.size() > 0) && m_load && !m_ready);
      chk("r_allowin", ms_allowin, m_allowin);
      retire = m_ready && ws_allowin && !do_flush;
      if (retire) begin
        chk("r_result", ws.final_result, exp_q[0][31:0]);
        chk("r_pc", ws.pc, exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (ok_now) begin
        if (live_ok) m_got = 1;
        void'(sram_q.pop_front());
      end
      if (do_flush) begin
        exp_q.delete();
        foreach (sram_q[i]) sram_q[i].dead = 1;
      end
      if (es_to_ms_valid && m_allowin) begin
        exp_q.push_back({es_pc, es_exp});
        m_needs = es_req;
        m_got   = 0;
        m_load  = (es_kind <= K_LDHU);
        if (es_req) sram_q.push_back('{es_rdata, 1'b0});
        es_pend = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
